// File: rtl/clock_pkg.sv
// Shared constants for the second, minute and hour stages of the clock chain.
// Digit widths, rollover limits and the default system clock rate.
package clock_pkg;

    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HOUR_MAX = 23;
    localparam int BCD_W    = 4;
    localparam int CLK_HZ   = 50000000;

    typedef logic [BCD_W-1:0] bcd_t;

    // Tens digit of a small decimal value
    function automatic bcd_t bcd_tens(input int value);
        return bcd_t'(value / 10);
    endfunction

    // Ones digit of a small decimal value
    function automatic bcd_t bcd_ones(input int value);
        return bcd_t'(value % 10);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-cycle strobe every DIV enabled cycles.
// Also reused for display scan timing.
module tick_prescaler
#(
    parameter int DIV = 4
)
(
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick_now
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] count;

    // Phase counter: cleared by clr, frozen while en is low
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

    assign tick_now = en && (count == LAST);

endmodule

// File: rtl/second_counter.sv
// Seconds stage of the clock chain: 1 Hz prescaler plus BCD 00-59 counter.
// Emits sec_tick per second and sec_carry on tick-driven rollover.
module second_counter
    import clock_pkg::*;
#(
    parameter int TICK_DIV = CLK_HZ,
    parameter int SEC_INIT = 0
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic             adj,
    output logic [BCD_W-1:0] sec_tens,
    output logic [BCD_W-1:0] sec_ones,
    output logic             sec_tick,
    output logic             sec_carry
);

    localparam bcd_t INIT_TENS = bcd_tens(SEC_INIT);
    localparam bcd_t INIT_ONES = bcd_ones(SEC_INIT);
    localparam bcd_t MAX_TENS  = bcd_tens(SEC_MAX);
    localparam bcd_t MAX_ONES  = bcd_ones(SEC_MAX);

    logic tick_now;
    logic at_max;
    logic step;

    tick_prescaler #(
        .DIV (TICK_DIV)
    ) u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .clr      (clr),
        .tick_now (tick_now)
    );

    assign at_max = (sec_tens == MAX_TENS) && (sec_ones == MAX_ONES);
    // adj and tick in the same cycle still advance by a single second
    assign step   = adj || tick_now;

    // BCD seconds and registered strobes; clear beats any advance
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sec_tens  <= INIT_TENS;
            sec_ones  <= INIT_ONES;
            sec_tick  <= 1'b0;
            sec_carry <= 1'b0;
        end else if (clr) begin
            sec_tens  <= '0;
            sec_ones  <= '0;
            sec_tick  <= 1'b0;
            sec_carry <= 1'b0;
        end else begin
            sec_tick  <= tick_now;
            sec_carry <= tick_now && at_max;
            if (step) begin
                if (at_max) begin
                    sec_tens <= '0;
                    sec_ones <= '0;
                end else if (sec_ones == 4'd9) begin
                    sec_ones <= '0;
                    sec_tens <= sec_tens + 1'b1;
                end else begin
                    sec_ones <= sec_ones + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_second_counter.sv
// Directed plus randomized checks of second_counter against an
// integer seconds/phase reference model.
module tb_second_counter;

    localparam int DIV  = 4;
    localparam int INIT = 58;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       clr = 1'b0;
    logic       adj = 1'b0;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       sec_tick;
    logic       sec_carry;

    int vectors = 0;
    int miscompares = 0;

    // reference model state
    int  m_sec = INIT;
    int  m_ph = 0;
    bit  m_tick = 1'b0;
    bit  m_carry = 1'b0;

    second_counter #(
        .TICK_DIV (DIV),
        .SEC_INIT (INIT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .clr       (clr),
        .adj       (adj),
        .sec_tens  (sec_tens),
        .sec_ones  (sec_ones),
        .sec_tick  (sec_tick),
        .sec_carry (sec_carry)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag);
        int val;
        val = int'(sec_tens) * 10 + int'(sec_ones);
        vectors++;
        assert (sec_tens <= 4'd5 && sec_ones <= 4'd9) else begin
            miscompares++;
            $error("FAIL %s digits: got %0d%0d required BCD <=59", tag, sec_tens, sec_ones);
        end
        vectors++;
        assert (val === m_sec) else begin
            miscompares++;
            $error("FAIL %s seconds: got %0d required %0d", tag, val, m_sec);
        end
        vectors++;
        assert (sec_tick === m_tick) else begin
            miscompares++;
            $error("FAIL %s sec_tick: got %0b required %0b", tag, sec_tick, m_tick);
        end
        vectors++;
        assert (sec_carry === m_carry) else begin
            miscompares++;
            $error("FAIL %s sec_carry: got %0b required %0b", tag, sec_carry, m_carry);
        end
    endtask

    // one clock with the given inputs, model update, then check
    task automatic step(input bit e, input bit c, input bit a, input string tag);
        bit t;
        en = e;
        clr = c;
        adj = a;
        @(posedge clk);
        t = e && (m_ph == DIV - 1);
        if (c) begin
            m_sec = 0;
            m_ph = 0;
            m_tick = 1'b0;
            m_carry = 1'b0;
        end else begin
            if (e) m_ph = (m_ph + 1) % DIV;
            m_carry = t && (m_sec == 59);
            m_tick = t;
            if (a || t) m_sec = (m_sec + 1) % 60;
        end
        #1;
        check(tag);
        clr = 1'b0;
        adj = 1'b0;
    endtask

    task automatic bound_fail(input string tag);
        vectors++;
        miscompares++;
        $error("FAIL %s: cycle budget expired, got timeout required target state", tag);
    endtask

    initial begin
        int n;
        int v;
        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset");
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("release");

        // 58 -> 59 after 4 cycles, 59 -> 00 with carry after 8
        for (int i = 0; i < 12; i++) step(1, 0, 0, "run");
        vectors++;
        assert (m_sec === 1 && int'(sec_tens) * 10 + int'(sec_ones) === 1) else begin
            miscompares++;
            $error("FAIL run12: got %0d%0d required 01", sec_tens, sec_ones);
        end

        // pause at phase 2 for 10 cycles
        n = 0;
        while (m_ph != 2 && n < 20) begin
            step(1, 0, 0, "to_ph2");
            n++;
        end
        if (m_ph != 2) bound_fail("to_ph2");
        for (int i = 0; i < 10; i++) step(0, 0, 0, "pause");
        step(1, 0, 0, "resume1");
        step(1, 0, 0, "resume_tick");
        vectors++;
        assert (sec_tick === 1'b1) else begin
            miscompares++;
            $error("FAIL resume_tick: got %0b required 1", sec_tick);
        end

        // adj with en low up to 59, then adj-only wrap (no carry/tick)
        n = 0;
        while (m_sec != 59 && n < 70) begin
            step(0, 0, 1, "adj_up");
            n++;
        end
        if (m_sec != 59) bound_fail("adj_up");
        step(0, 0, 1, "adj_wrap");
        vectors++;
        assert (sec_carry === 1'b0 && sec_tick === 1'b0 && sec_ones === 4'd0 && sec_tens === 4'd0) else begin
            miscompares++;
            $error("FAIL adj_wrap: got %0d%0d c%0b t%0b required 00 c0 t0",
                   sec_tens, sec_ones, sec_carry, sec_tick);
        end

        // adj coincident with tick at 30 -> 31
        n = 0;
        while (!(m_sec == 30 && m_ph == DIV - 1) && n < 400) begin
            step(1, 0, (m_sec < 29 && m_ph != DIV - 1), "to_30");
            n++;
        end
        if (!(m_sec == 30 && m_ph == DIV - 1)) bound_fail("to_30");
        step(1, 0, 1, "adj_tick");
        vectors++;
        assert (sec_tens === 4'd3 && sec_ones === 4'd1 && sec_tick === 1'b1) else begin
            miscompares++;
            $error("FAIL adj_tick: got %0d%0d t%0b required 31 t1", sec_tens, sec_ones, sec_tick);
        end

        // clear mid-period at 45, held 3 cycles
        n = 0;
        while (!(m_sec == 45 && m_ph == 1) && n < 400) begin
            step(1, 0, (m_sec < 44 && m_ph == 0), "to_45");
            n++;
        end
        if (!(m_sec == 45 && m_ph == 1)) bound_fail("to_45");
        for (int i = 0; i < 3; i++) step(1, 1, 0, "clr");
        for (int i = 0; i < DIV; i++) step(1, 0, 0, "post_clr");
        vectors++;
        assert (sec_tick === 1'b1 && sec_ones === 4'd1) else begin
            miscompares++;
            $error("FAIL post_clr_tick: got t%0b ones %0d required t1 ones 1", sec_tick, sec_ones);
        end

        // async reset at 59 with a tick pending
        n = 0;
        while (!(m_sec == 59 && m_ph == DIV - 1) && n < 400) begin
            step(1, 0, 0, "to_59");
            n++;
        end
        if (!(m_sec == 59 && m_ph == DIV - 1)) bound_fail("to_59");
        #2;
        reset = 1'b1;
        #1;
        m_sec = INIT;
        m_ph = 0;
        m_tick = 1'b0;
        m_carry = 1'b0;
        check("async_reset");
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 2 * DIV; i++) step(1, 0, 0, "after_reset");

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            v = int'($urandom_range(0, 99));
            step(v >= 10, v == 0, v >= 93, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
